// File: rtl/secded_decoder.sv
// secded_decoder: two-byte input, bit-serial Hamming(15,11)+overall-parity SECDED decoder.
// Optional macro SECDED_ERRCNT_EN adds saturating SingleCnt/DoubleCnt error counters.
`default_nettype none

module secded_decoder #(
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [W-1:0]  InData,
  input  logic          In_valid,
  output logic          In_ready,
  output logic [10:0]   Data,
  output logic [1:0]    Status,
`ifdef SECDED_ERRCNT_EN
  output logic [7:0]    SingleCnt,
  output logic [7:0]    DoubleCnt,
`endif
  output logic          Out_valid,
  input  logic          Out_ready
);

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_DOUBLE = 2'b10;

  state_t      state, state_n;
  logic [15:0] cw;
  logic [3:0]  syn, syn_n;
  logic        par, par_n;
  logic [4:0]  idx;
  logic [3:0]  pos;
  logic [15:0] flip_mask;
  logic [15:0] fixed_cw;
  logic [1:0]  status_n;
  logic [10:0] data_q;
  logic [1:0]  status_q;

  // idx[4] set means all 16 bits have been folded into syn/par
  wire calc_done = idx[4];

  function automatic logic [10:0] extract(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_LO;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_LO:    if (In_valid)  state_n = S_HI;
      S_HI:    if (In_valid)  state_n = S_CALC;
      S_CALC:  if (calc_done) state_n = S_OUT;
      S_OUT:   if (Out_ready) state_n = S_LO;
      default: state_n = S_LO;
    endcase
  end

  assign In_ready  = (state == S_LO) || (state == S_HI);
  assign Out_valid = (state == S_OUT);
  assign Data      = data_q;
  assign Status    = status_q;

  // Fold STEP codeword bits into the syndrome and overall parity
  always_comb begin
    syn_n = syn;
    par_n = par;
    pos   = '0;
    for (int k = 0; k < STEP; k++) begin
      pos = idx[3:0] + 4'(k);
      if (cw[pos]) begin
        syn_n = syn_n ^ pos;
        par_n = ~par_n;
      end
    end
  end

  // Odd overall parity means one flipped bit; syndrome 0 points at p0 itself
  always_comb begin
    flip_mask = par ? (16'd1 << syn) : 16'd0;
    fixed_cw  = cw ^ flip_mask;
    if (par)             status_n = ST_SINGLE;
    else if (syn != 4'd0) status_n = ST_DOUBLE;
    else                 status_n = ST_CLEAN;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cw       <= '0;
      syn      <= '0;
      par      <= 1'b0;
      idx      <= '0;
      data_q   <= '0;
      status_q <= ST_CLEAN;
    end else begin
      case (state)
        S_LO: if (In_valid) cw[7:0] <= InData[7:0];
        S_HI: if (In_valid) begin
          cw[15:8] <= InData[7:0];
          syn      <= '0;
          par      <= 1'b0;
          idx      <= '0;
        end
        S_CALC: begin
          if (!calc_done) begin
            syn <= syn_n;
            par <= par_n;
            idx <= idx + 5'(STEP);
          end else begin
            data_q   <= extract(fixed_cw);
            status_q <= status_n;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SECDED_ERRCNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      SingleCnt <= '0;
      DoubleCnt <= '0;
    end else if (state == S_CALC && calc_done) begin
      if (status_n == ST_SINGLE && SingleCnt != 8'hFF) SingleCnt <= SingleCnt + 8'd1;
      if (status_n == ST_DOUBLE && DoubleCnt != 8'hFF) DoubleCnt <= DoubleCnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: vector table, hand sequences and random encode/corrupt checks.
`default_nettype none

module tb_secded_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [10:0] data;
  logic [1:0]  status;

  logic [7:0]  in_data4;
  logic        in_valid4, out_ready4;
  logic        in_ready4, out_valid4;
  logic [10:0] data4;
  logic [1:0]  status4;

`ifdef SECDED_ERRCNT_EN
  logic [7:0] single_cnt, double_cnt, single_cnt4, double_cnt4;
`endif

  secded_decoder #(.W(8), .STEP(1)) u_dut (
    .Clk(clk), .Reset_n(rst_n), .InData(in_data), .In_valid(in_valid),
    .In_ready(in_ready), .Data(data), .Status(status),
`ifdef SECDED_ERRCNT_EN
    .SingleCnt(single_cnt), .DoubleCnt(double_cnt),
`endif
    .Out_valid(out_valid), .Out_ready(out_ready)
  );

  secded_decoder #(.W(8), .STEP(4)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .InData(in_data4), .In_valid(in_valid4),
    .In_ready(in_ready4), .Data(data4), .Status(status4),
`ifdef SECDED_ERRCNT_EN
    .SingleCnt(single_cnt4), .DoubleCnt(double_cnt4),
`endif
    .Out_valid(out_valid4), .Out_ready(out_ready4)
  );

  typedef struct {
    logic [15:0] cw;
    logic [10:0] exp_data;
    logic [1:0]  exp_status;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_single = 0;
  int exp_double = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cnt();
`ifdef SECDED_ERRCNT_EN
    check("single_cnt", 32'(single_cnt), 32'(exp_single));
    check("double_cnt", 32'(double_cnt), 32'(exp_double));
`endif
  endtask

  function automatic logic [10:0] extract(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  // Reference encoder: Hamming parity over non-power-of-two positions, then overall parity
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic b;
    c = '0;
    c[15:9] = d[10:4];
    c[7:5]  = d[3:1];
    c[3]    = d[0];
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int j = 3; j < 16; j++)
        if (((j & p) != 0) && ((j & (j - 1)) != 0)) b = b ^ c[j];
      c[p] = b;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic send_bytes(input logic [15:0] cw, output bit ok);
    int w;
    ok = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      in_data  = (b == 0) ? cw[7:0] : cw[15:8];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Returns at the negedge where Out_valid is first seen high
  task automatic send_word(input logic [15:0] cw, output int lat, output bit ok);
    send_bytes(cw, ok);
    lat = 0;
    if (!ok) return;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (lat >= 100) begin
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_after_ack", 32'(out_valid), 32'd0);
    check("in_ready_after_ack", 32'(in_ready), 32'd1);
  endtask

  task automatic do_word(input string name, input logic [15:0] cw,
                         input logic [10:0] exp_d, input logic [1:0] exp_s);
    int lat;
    bit ok;
    send_word(cw, lat, ok);
    if (!ok) return;
    if (exp_s == 2'b01 && exp_single < 255) exp_single++;
    if (exp_s == 2'b10 && exp_double < 255) exp_double++;
    check({name, "_latency"}, 32'(lat), 32'd17);
    check({name, "_data"}, 32'(data), 32'(exp_d));
    check({name, "_status"}, 32'(status), 32'(exp_s));
    check_cnt();
    ack();
  endtask

  vec_t vecs[7];

  initial begin
    logic [10:0] rd;
    logic [15:0] rcw;
    int          nflip, pa, pb, lat, w;
    bit          ok;
    logic [15:0] cws4[2];
    logic [10:0] exp_d4[2];
    logic [1:0]  exp_s4[2];

    vecs[0] = '{16'h0000, 11'h000, 2'b00};
    vecs[1] = '{16'hFFFF, 11'h7FF, 2'b00};
    vecs[2] = '{16'h0020, 11'h000, 2'b01};
    vecs[3] = '{16'h0001, 11'h000, 2'b01};
    vecs[4] = '{16'h7FFF, 11'h7FF, 2'b01};
    vecs[5] = '{16'h0028, 11'h003, 2'b10};
    vecs[6] = '{16'h0003, 11'h000, 2'b10};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check_cnt();
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_word($sformatf("vec%0d", i), vecs[i].cw, vecs[i].exp_data, vecs[i].exp_status);

    // Double error held in OUT while the producer keeps offering a byte
    send_word(16'h0028, lat, ok);
    if (ok) begin
      exp_double++;
      check("hold_status", 32'(status), 32'd2);
      check("hold_data", 32'(data), 32'h003);
      check_cnt();
      for (int c = 0; c < 5; c++) begin
        in_data = 8'hAA; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_data_stable", 32'(data), 32'h003);
        check("hold_status_stable", 32'(status), 32'd2);
      end
      in_valid = 1'b0;
      ack();
    end

    // Reset in the middle of CALC discards the partial word
    send_bytes(16'h0020, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_single = 0; exp_double = 0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_status", 32'(status), 32'd0);
    check_cnt();
    @(negedge clk);
    rst_n = 1'b1;
    do_word("post_rst", 16'hFFFF, 11'h7FF, 2'b00);

    // Random words: clean, one flip (corrected) or two flips (reported, uncorrected)
    for (int n = 0; n < 40; n++) begin
      rd    = 11'($urandom_range(0, 2047));
      rcw   = encode(rd);
      nflip = $urandom_range(0, 2);
      pa    = $urandom_range(0, 15);
      pb    = (pa + $urandom_range(1, 15)) % 16;
      if (nflip >= 1) rcw[pa] = ~rcw[pa];
      if (nflip == 2) rcw[pb] = ~rcw[pb];
      if (nflip == 2) do_word($sformatf("rand%0d", n), rcw, extract(rcw), 2'b10);
      else            do_word($sformatf("rand%0d", n), rcw, rd, 2'(nflip));
    end

    // STEP=4 instance: five-cycle latency
    cws4[0] = 16'hFFFF; exp_d4[0] = 11'h7FF; exp_s4[0] = 2'b00;
    cws4[1] = 16'h0020; exp_d4[1] = 11'h000; exp_s4[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        in_data4  = (b == 0) ? cws4[i][7:0] : cws4[i][15:8];
        in_valid4 = 1'b1;
        check("s4_in_ready", 32'(in_ready4), 32'd1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
      end
      lat = 0;
      w   = 0;
      while (w == 0) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (out_valid4 || lat >= 100) w = 1;
      end
      check("s4_out_valid", 32'(out_valid4), 32'd1);
      check("s4_latency", 32'(lat), 32'd5);
      check("s4_data", 32'(data4), 32'(exp_d4[i]));
      check("s4_status", 32'(status4), 32'(exp_s4[i]));
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
      @(negedge clk);
      check("s4_ack_out_valid", 32'(out_valid4), 32'd0);
    end
`ifdef SECDED_ERRCNT_EN
    check("s4_single_cnt", 32'(single_cnt4), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
